lfsr_rng_arbiter: RTL and testbench

//  Shares one Fibonacci LFSR random-number source among NUM_REQ requesters.
//  - Round-robin arbitration picks one requester.
//  - The LFSR is stepped STEPS times so each delivered word carries fresh bits.
//  - The word is returned with a one-hot grant.
//  - Also owns seeding: software loads a seed while the block is idle.

---
 rtl/lfsr_rng_arbiter.sv | 154 +++++++++++++++
 tb/tb_lfsr_rng_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_arbiter.sv
// Shared Fibonacci LFSR random source with round-robin requester arbitration.
// Define LFSR_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module lfsr_rng_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int STEPS   = WIDTH,
  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW     = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seed_valid,
  input  logic [WIDTH-1:0]   seed_data,
  output logic               seed_ready,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rnd_valid,
  output logic [WIDTH-1:0]   rnd_data,
  output logic [IW-1:0]      rnd_id,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      rnd_id_q, rnd_id_d;
  logic [WIDTH-1:0]   rnd_data_q, rnd_data_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               rnd_valid_q, rnd_valid_d;
  logic [IW-1:0]      win;
  logic               fb;

  // Feedback taps; only the three supported widths have a polynomial.
  if (WIDTH == 4) begin : g_w4
    assign fb = lfsr_q[3] ^ lfsr_q[2];
  end else if (WIDTH == 8) begin : g_w8
    assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  end else if (WIDTH == 16) begin : g_w16
    assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  end else begin : g_bad
    $error("lfsr_rng_arbiter: WIDTH must be 4, 8 or 16");
    assign fb = 1'b0;
  end

`ifdef LFSR_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) win = IW'(i);
    end
  end
`else
  logic [IW-1:0] last_gnt_q, last_gnt_d;

  // Round-robin: scan upward from the slot after the last winner.
  always_comb begin
    logic found;
    int   k;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(last_gnt_q) + 1 + i) % NUM_REQ;
      if (!found && req[k]) begin
        win   = IW'(k);
        found = 1'b1;
      end
    end
  end

  // Winner pointer advances once the word has been handed out.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (state_q == DONE) last_gnt_d = rnd_id_q;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_gnt_q <= IW'(NUM_REQ - 1);
    else        last_gnt_q <= last_gnt_d;
  end
`endif

  // Next-state, LFSR stepping and output staging.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    rnd_id_d    = rnd_id_q;
    rnd_data_d  = rnd_data_q;
    gnt_d       = '0;
    rnd_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (seed_valid) begin
          lfsr_d = (seed_data == '0) ? '1 : seed_data;
        end else if (|req) begin
          rnd_id_d = win;
          cnt_d    = '0;
          state_d  = GEN;
        end
      end
      GEN: begin
        lfsr_d = {lfsr_q[WIDTH-2:0], fb};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(STEPS - 1)) begin
          state_d     = DONE;
          rnd_valid_d = 1'b1;
          gnt_d       = NUM_REQ'(1) << rnd_id_q;
          rnd_data_d  = lfsr_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= '1;
      cnt_q       <= '0;
      rnd_id_q    <= '0;
      rnd_data_q  <= '0;
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      rnd_id_q    <= rnd_id_d;
      rnd_data_q  <= rnd_data_d;
      gnt_q       <= gnt_d;
      rnd_valid_q <= rnd_valid_d;
    end
  end

  assign seed_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign gnt        = gnt_q;
  assign rnd_valid  = rnd_valid_q;
  assign rnd_data   = rnd_data_q;
  assign rnd_id     = rnd_id_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Directed bench for lfsr_rng_arbiter: W8/STEPS=8 and W8/STEPS=1 instances.
// Expected words are hand-derived from the 8-bit tap set.
module tb_lfsr_rng_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       seed_valid0 = 1'b0;
  logic [7:0] seed_data0 = '0;
  logic       seed_ready0;
  logic [3:0] req0 = '0;
  logic [3:0] gnt0;
  logic       rnd_valid0;
  logic [7:0] rnd_data0;
  logic [1:0] rnd_id0;
  logic       busy0;

  logic       seed_valid1 = 1'b0;
  logic [7:0] seed_data1 = '0;
  logic       seed_ready1;
  logic [3:0] req1 = '0;
  logic [3:0] gnt1;
  logic       rnd_valid1;
  logic [7:0] rnd_data1;
  logic [1:0] rnd_id1;
  logic       busy1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lfsr_rng_arbiter #(.NUM_REQ(4), .WIDTH(8), .STEPS(8)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_valid (seed_valid0),
    .seed_data  (seed_data0),
    .seed_ready (seed_ready0),
    .req        (req0),
    .gnt        (gnt0),
    .rnd_valid  (rnd_valid0),
    .rnd_data   (rnd_data0),
    .rnd_id     (rnd_id0),
    .busy       (busy0)
  );

  lfsr_rng_arbiter #(.NUM_REQ(4), .WIDTH(8), .STEPS(1)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_valid (seed_valid1),
    .seed_data  (seed_data1),
    .seed_ready (seed_ready1),
    .req        (req1),
    .gnt        (gnt1),
    .rnd_valid  (rnd_valid1),
    .rnd_data   (rnd_data1),
    .rnd_id     (rnd_id1),
    .busy       (busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid0(input int maxc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rnd_valid0 && n < maxc);
    chk("valid_timeout", 32'(rnd_valid0), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] seq [8];
    logic [1:0] rr  [5];
    int n;
    seq = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1, 8'hC2, 8'h85, 8'h0B};
`ifdef LFSR_ARB_FIXED_PRIO_EN
    rr = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    rr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif

    // reset values
    tick();
    tick();
    chk("rst_valid", 32'(rnd_valid0), 32'd0);
    chk("rst_gnt", 32'(gnt0), 32'd0);
    chk("rst_data", 32'(rnd_data0), 32'd0);
    chk("rst_id", 32'(rnd_id0), 32'd0);
    chk("rst_ready", 32'(seed_ready0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    rst_n = 1'b1;
    tick();

    // post-reset word with intermediate LFSR states
    req0 = 4'b0001;
    tick();
    chk("gen_busy", 32'(busy0), 32'd1);
    chk("gen_ready", 32'(seed_ready0), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("lfsr_step", 32'(u_dut0.lfsr_q), 32'(seq[i]));
    end
    chk("t1_valid", 32'(rnd_valid0), 32'd1);
    chk("t1_gnt", 32'(gnt0), 32'b0001);
    chk("t1_id", 32'(rnd_id0), 32'd0);
    chk("t1_data", 32'(rnd_data0), 32'h0B);
    req0 = 4'b0000;
    tick();
    chk("t1_pulse", 32'(rnd_valid0), 32'd0);
    chk("t1_gnt_off", 32'(gnt0), 32'd0);
    chk("t1_hold", 32'(rnd_data0), 32'h0B);

    // grant order with all requesters active
    do_reset();
    req0 = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_valid0(20, n);
      chk("rr_id", 32'(rnd_id0), 32'(rr[g]));
      chk("rr_gnt", 32'(gnt0), 32'(4'b0001 << rr[g]));
      if (g == 4) req0 = 4'b0000;
    end
    tick();

    // zero seed falls back to all-ones
    seed_valid0 = 1'b1;
    seed_data0  = 8'h00;
    tick();
    seed_valid0 = 1'b0;
    chk("seed0_ready", 32'(seed_ready0), 32'd1);
    chk("seed0_lfsr", 32'(u_dut0.lfsr_q), 32'hFF);
    req0 = 4'b0001;
    wait_valid0(20, n);
    chk("seed0_lat", 32'(n), 32'd9);
    chk("seed0_data", 32'(rnd_data0), 32'h0B);
    req0 = 4'b0000;
    tick();

    // seed attempt during GEN is dropped
    seed_valid0 = 1'b1;
    seed_data0  = 8'h00;
    tick();
    seed_valid0 = 1'b0;
    req0 = 4'b0001;
    tick();
    seed_valid0 = 1'b1;
    seed_data0  = 8'h55;
    chk("gen_seed_ready", 32'(seed_ready0), 32'd0);
    tick();
    tick();
    seed_valid0 = 1'b0;
    wait_valid0(20, n);
    chk("gen_seed_data", 32'(rnd_data0), 32'h0B);
    req0 = 4'b0000;
    tick();

    // reset in the middle of GEN
    req0 = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rnd_valid0), 32'd0);
    chk("midrst_gnt", 32'(gnt0), 32'd0);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_data", 32'(rnd_data0), 32'd0);
    tick();
    chk("midrst_valid2", 32'(rnd_valid0), 32'd0);
    rst_n = 1'b1;
    wait_valid0(20, n);
    chk("midrst_lat", 32'(n), 32'd9);
    chk("midrst_word", 32'(rnd_data0), 32'h0B);
    req0 = 4'b0000;
    tick();

    // STEPS=1 instance: seeded single step
    seed_valid1 = 1'b1;
    seed_data1  = 8'h3C;
    tick();
    seed_valid1 = 1'b0;
    req1 = 4'b0001;
    tick();
    chk("s1_early", 32'(rnd_valid1), 32'd0);
    tick();
    chk("s1_valid", 32'(rnd_valid1), 32'd1);
    chk("s1_data", 32'(rnd_data1), 32'h79);
    chk("s1_gnt", 32'(gnt1), 32'b0001);
    req1 = 4'b0000;
    tick();

    // seed and request together: seed first
    seed_valid1 = 1'b1;
    seed_data1  = 8'h3C;
    req1 = 4'b0001;
    tick();
    seed_valid1 = 1'b0;
    chk("s1_both_idle", 32'(busy1), 32'd0);
    tick();
    chk("s1_both_busy", 32'(busy1), 32'd1);
    tick();
    chk("s1_both_valid", 32'(rnd_valid1), 32'd1);
    chk("s1_both_data", 32'(rnd_data1), 32'h79);
    req1 = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
